aes_ct_outbuf: RTL

//  Output stage directly downstream of the AES plaintext/ciphertext monitor.
//  - Captures each 128-bit ciphertext the monitor releases (valid_i) into a small FIFO.
//  - Returns the ciphertext to the bus as 32-bit words through a request/valid read port.
//  - Latches the monitor's override as a sticky alarm. While the alarm is set, all ciphertext output is blocked.

---
 rtl/aes_ct_outbuf_if.sv | 28 ++
 rtl/aes_ct_outbuf.sv | 117 +++++++++++
 2 files changed

// File: rtl/aes_ct_outbuf_if.sv
// Bus bundle between the AES monitor stage, this output buffer and the reader.
interface aes_ct_outbuf_if #(
  parameter int unsigned CNT_W = 8
);
  logic [127:0]     ct_i;
  logic             valid_i;
  logic             override_i;
  logic             clr_alarm_i;
  logic             rd_req_i;
  logic [31:0]      rd_data_o;
  logic             rd_valid_o;
  logic             blk_avail_o;
  logic             full_o;
  logic             alarm_o;
  logic [CNT_W-1:0] ovr_cnt_o;

  // Buffer side
  modport slave (
    input  ct_i, valid_i, override_i, clr_alarm_i, rd_req_i,
    output rd_data_o, rd_valid_o, blk_avail_o, full_o, alarm_o, ovr_cnt_o
  );

  // Monitor / reader side
  modport master (
    output ct_i, valid_i, override_i, clr_alarm_i, rd_req_i,
    input  rd_data_o, rd_valid_o, blk_avail_o, full_o, alarm_o, ovr_cnt_o
  );
endinterface

// File: rtl/aes_ct_outbuf.sv
// AES ciphertext output buffer: block FIFO, 32-bit word readout, sticky
// override alarm that blocks and flushes all buffered ciphertext.
module aes_ct_outbuf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  aes_ct_outbuf_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, XFER} state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             alarm_q, alarm_d;
  logic             ovr_prev_q;
  logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [127:0]     mem_q [DEPTH];

  logic full, avail, serve, pop, push;

  // Handshake decode; an override cycle suppresses both push and readout
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    avail = (count_q != '0) && !alarm_q;
    serve = bus.rd_req_i && !bus.override_i && ((state_q == XFER) || avail);
    pop   = serve && (idx_q == 2'd3);
    push  = bus.valid_i && !bus.override_i && !alarm_q && (!full || pop);
  end

  // Next-state for FIFO bookkeeping, readout FSM, alarm and counter
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
    alarm_d    = bus.override_i ? 1'b1 : (bus.clr_alarm_i ? 1'b0 : alarm_q);
    ovr_cnt_d  = ovr_cnt_q;
    if (bus.override_i && !ovr_prev_q && (ovr_cnt_q != '1))
      ovr_cnt_d = ovr_cnt_q + CNT_W'(1);

    if (bus.override_i) begin
      // Flush everything including any half-read head block
      state_d  = IDLE;
      idx_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (serve) begin
        // The IDLE->XFER request already returns word 0
        rd_valid_d = 1'b1;
        rd_data_d  = mem_q[rd_ptr_q][{idx_q, 5'd0} +: 32];
        idx_d      = idx_q + 2'd1;
        if (pop) state_d = (count_d != '0) ? XFER : IDLE;
        else     state_d = XFER;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      alarm_q    <= 1'b0;
      ovr_prev_q <= 1'b0;
      ovr_cnt_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      alarm_q    <= alarm_d;
      ovr_prev_q <= bus.override_i;
      ovr_cnt_q  <= ovr_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Block storage; contents are meaningless until counted in, so no reset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.ct_i;
  end

  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.blk_avail_o = avail;
  assign bus.full_o      = full;
  assign bus.alarm_o     = alarm_q;
  assign bus.ovr_cnt_o   = ovr_cnt_q;
endmodule
